// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ISA constants and FSM state encoding
// for the multicycle accumulator core.
package cpu_pkg;

  localparam logic [3:0] OP_MOV  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_IN   = 4'b0111;
  localparam logic [3:0] OP_OUT  = 4'b1000;
  localparam logic [3:0] OP_STOP = 4'b1111;

  localparam int         IND       = 3;
  localparam logic [3:0] MOV_CONST = 4'b1000;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH0,
    S_FETCH1,
    S_DECODE,
    S_FETCH2,
    S_FETCH3,
    S_RD2,
    S_CAP2,
    S_RD3,
    S_CAP3,
    S_RDP1,
    S_CAPP1,
    S_IN_WAIT,
    S_WR,
    S_OUT,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_seq_alu.sv
// cpu_seq_alu: unsigned modulo arithmetic unit;
// divide by zero yields zero.
module cpu_seq_alu
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    oc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] f
);

  always_comb begin
    f = a;
    case (oc)
      OP_ADD: f = a + b;
      OP_SUB: f = a - b;
      OP_MUL: f = a * b;
      OP_DIV: f = (b == '0) ? '0 : a / b;
      default: f = a;
    endcase
  end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multicycle accumulator CPU with direct/indirect
// operands, single-port sync memory, IN/OUT handshakes.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int PC_INIT    = 8,
  parameter int SP_INIT    = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_in,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  in_ready,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp
);

  state_t state, state_nx, dest_nx;

  logic [15:0]           ir;
  logic [DATA_WIDTH-1:0] a_q, b_q, alu_f;
  logic [ADDR_WIDTH-1:0] ptr, p1;
  logic                  ptr_ok, p1_ok;

  logic [3:0] op, f1, f2, f3;
  logic [ADDR_WIDTH-1:0] fa1, fa2, fa3, wa, mem_ptr;
  logic is_mov, is_in, is_out, is_stop, is_arith, movc;

  assign op  = ir[15:12];
  assign f1  = ir[11:8];
  assign f2  = ir[7:4];
  assign f3  = ir[3:0];
  assign fa1 = ADDR_WIDTH'(ir[10:8]);
  assign fa2 = ADDR_WIDTH'(ir[6:4]);
  assign fa3 = ADDR_WIDTH'(ir[2:0]);
  assign wa  = f1[IND] ? p1 : fa1;
  assign mem_ptr = mem_in[ADDR_WIDTH-1:0];

  assign is_mov   = (op == OP_MOV);
  assign is_in    = (op == OP_IN);
  assign is_out   = (op == OP_OUT);
  assign is_stop  = (op == OP_STOP);
  assign is_arith = op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  assign movc     = is_mov && (f3 == MOV_CONST);

  assign in_ready = (state == S_IN_WAIT);
  assign halted   = (state == S_HALT);

  cpu_seq_alu #(.DW(DATA_WIDTH)) u_alu (
    .oc (op),
    .a  (b_q),
    .b  (mem_in),
    .f  (alu_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dest_nx  = S_RD2;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (is_in)     dest_nx = S_IN_WAIT;
    else if (movc) dest_nx = S_FETCH2;
    unique case (state)
      S_INIT:   state_nx = S_FETCH0;
      S_FETCH0: begin
        mem_addr = pc;
        state_nx = S_FETCH1;
      end
      S_FETCH1: state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_out:  state_nx = S_RDP1;
          is_stop: state_nx = S_HALT;
          (is_mov | is_in | is_arith):
            state_nx = f1[IND] ? S_RDP1 : dest_nx;
          default: state_nx = S_FETCH0;
        endcase
      end
      S_RDP1: begin
        mem_addr = p1_ok ? p1 : fa1;
        state_nx = (f1[IND] && !p1_ok) ? S_CAPP1 : S_OUT;
      end
      S_CAPP1:  state_nx = is_out ? S_RDP1 : dest_nx;
      S_FETCH2: begin
        mem_addr = pc;
        state_nx = S_FETCH3;
      end
      S_FETCH3: state_nx = S_RD3;
      S_RD2: begin
        mem_addr = ptr_ok ? ptr : fa2;
        state_nx = S_CAP2;
      end
      S_CAP2: begin
        if (f2[IND] && !ptr_ok) state_nx = S_RD2;
        else                    state_nx = is_mov ? S_WR : S_RD3;
      end
      S_RD3: begin
        mem_addr = ptr_ok ? ptr : fa3;
        state_nx = S_CAP3;
      end
      S_CAP3: begin
        // the MOV-constant marker overlaps the IND bit of F3
        if (f3[IND] && !ptr_ok && !is_mov) state_nx = S_RD3;
        else                               state_nx = S_WR;
      end
      S_IN_WAIT: if (in_valid) state_nx = S_WR;
      S_WR: begin
        mem_we   = 1'b1;
        mem_addr = wa;
        mem_data = a_q;
        state_nx = S_FETCH0;
      end
      S_OUT:  state_nx = S_FETCH0;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      sp     <= '0;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ptr    <= '0;
      p1     <= '0;
      ptr_ok <= 1'b0;
      p1_ok  <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          pc <= ADDR_WIDTH'(PC_INIT);
          sp <= ADDR_WIDTH'(SP_INIT);
        end
        S_FETCH1: begin
          ir     <= mem_in[15:0];
          pc     <= pc + 1'b1;
          ptr_ok <= 1'b0;
          p1_ok  <= 1'b0;
        end
        S_CAPP1: begin
          p1    <= mem_ptr;
          p1_ok <= 1'b1;
        end
        S_FETCH3: begin
          b_q <= mem_in;
          pc  <= pc + 1'b1;
        end
        S_CAP2: begin
          if (f2[IND] && !ptr_ok) begin
            ptr    <= mem_ptr;
            ptr_ok <= 1'b1;
          end else begin
            b_q    <= mem_in;
            a_q    <= mem_in;
            ptr_ok <= 1'b0;
          end
        end
        S_CAP3: begin
          if (f3[IND] && !ptr_ok && !is_mov) begin
            ptr    <= mem_ptr;
            ptr_ok <= 1'b1;
          end else begin
            a_q    <= alu_f;
            ptr_ok <= 1'b0;
          end
        end
        S_IN_WAIT: if (in_valid) a_q <= in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == S_OUT);
      if (state == S_OUT) out <= mem_in;
    end
  end

endmodule
